// File: rtl/e_mdu_pkg.sv
// Shared multiply/divide definitions: op encodings and latencies, also used by the decode-stage decoder.
package e_mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers; results commit on the last RUN edge.
module e_mdu
    import e_mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   opa;
    logic [DATA_W-1:0]   opb;
    logic [2:0]          op_q;

    logic [63:0]         prod_s;
    logic [63:0]         prod_u;
    logic                div_signed;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W-1:0]   b_safe;
    logic [DATA_W-1:0]   q_mag;
    logic [DATA_W-1:0]   r_mag;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;

    // Datapath from latched operands; signed divide works on magnitudes so MIN/-1 wraps cleanly.
    always_comb begin
        prod_s     = {{32{opa[31]}}, opa} * {{32{opb[31]}}, opb};
        prod_u     = {32'd0, opa} * {32'd0, opb};
        div_signed = (op_q == OP_DIV);
        a_mag      = (div_signed && opa[31]) ? DATA_W'(-opa) : opa;
        b_mag      = (div_signed && opb[31]) ? DATA_W'(-opb) : opb;
        b_safe     = (b_mag == '0) ? DATA_W'(1) : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quot       = (div_signed && (opa[31] ^ opb[31])) ? DATA_W'(-q_mag) : q_mag;
        rem        = (div_signed && opa[31]) ? DATA_W'(-r_mag) : r_mag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            op_q  <= OP_NONE;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                opa   <= rs_val;
                                opb   <= rt_val;
                                op_q  <= op;
                                cnt   <= CNT_W'(MULT_CYCLES - 1);
                                state <= ST_RUN;
                                busy  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                opa   <= rs_val;
                                opb   <= rt_val;
                                op_q  <= op;
                                cnt   <= CNT_W'(DIV_CYCLES - 1);
                                state <= ST_RUN;
                                busy  <= 1'b1;
                            end
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored here; the pipeline stalls on busy.
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        case (op_q)
                            OP_MULT: begin
                                hi <= prod_s[63:32];
                                lo <= prod_s[31:0];
                            end
                            OP_MULTU: begin
                                hi <= prod_u[63:32];
                                lo <= prod_u[31:0];
                            end
                            OP_DIV, OP_DIVU: begin
                                if (opb != '0) begin
                                    hi <= rem;
                                    lo <= quot;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Randomized self-checking bench for e_mdu against an arithmetic model of HI/LO and busy timing.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_tests;
    int unsigned n_fail;
    logic [63:0] exp_hl;

    e_mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Architectural result of one operation, computed with wide integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd1: begin p = 64'(sa * sb); return p; end
            3'd2: begin p = ua * ub; return p; end
            3'd3: begin
                if (b == 32'd0) return hl;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return hl;
                p = ua / ub;
                ua = ua % ub;
                return {ua[31:0], p[31:0]};
            end
            3'd5: return {a, hl[31:0]};
            3'd6: return {hl[63:32], a};
            default: return hl;
        endcase
    endfunction

    function automatic int unsigned latency(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd2) return 5;
        if (o == 3'd3 || o == 3'd4) return 10;
        return 0;
    endfunction

    // Issue one request, disturb inputs during RUN, and check busy and HI/LO every cycle.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int junk_cycle);
        int unsigned n;
        logic [63:0] nxt;
        n   = latency(o);
        nxt = model(o, a, b, exp_hl);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        op     = 3'd0;
        rs_val = $urandom;
        rt_val = $urandom;
        for (int k = 0; k < int'(n); k++) begin
            chk("busy_run", 64'(busy), 64'd1);
            chk("hilo_hold", {hi, lo}, exp_hl);
            if (k == junk_cycle) begin
                start  = 1'b1;
                op     = 3'($urandom_range(1, 6));
                rs_val = $urandom;
                rt_val = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start  = 1'b0;
        exp_hl = nxt;
        chk("busy_done", 64'(busy), 64'd0);
        chk("hilo_result", {hi, lo}, exp_hl);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_hl  = 64'd0;
        reset   = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        rs_val  = 32'd0;
        rt_val  = 32'd0;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, -1);
        chk("mult_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(3'd2, 32'hFFFF_FFFE, 32'd3, -1);
        chk("multu_exact", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1);
        chk("div_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd4, 32'd7, 32'd0, -1);
        chk("divu_zero", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(3'd6, 32'h1234_5678, 32'd0, -1);
        chk("mtlo_exact", 64'(lo), 64'h1234_5678);
        do_op(3'd5, 32'hCAFE_F00D, 32'd0, -1);
        do_op(3'd7, 32'hDEAD_BEEF, 32'd1, -1);

        // Reset in the middle of a divide clears everything and no late write follows.
        @(negedge clk);
        start  = 1'b1;
        op     = 3'd3;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        exp_hl = 64'd0;
        @(negedge clk);
        start  = 1'b1;
        op     = 3'd6;
        rs_val = 32'hA5A5_0001;
        reset  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_hl = {32'd0, 32'hA5A5_0001};
        chk("first_edge_start", {hi, lo}, exp_hl);
        repeat (12) @(negedge clk);
        chk("no_late_write", {hi, lo}, exp_hl);
        chk("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), rand_val(), rand_val(), $urandom_range(0, 12) - 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
